// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      HI,
      LO,
      WRITE,
      CSUM
   } state_t;

   localparam logic [7:0] START_BYTE = 8'hA5;
   localparam int         WORD_W     = 16;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and frame status of the loader.
interface imem_loader_if #(
   parameter int ADDR_W = 8
);
   import imem_loader_pkg::*;

   logic              rx_valid;
   logic              rx_ready;
   logic [7:0]        rx_data;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [WORD_W-1:0] imem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   word_count;

   // master: the loader itself; slave: byte source, memory and pipeline side
   modport master (
      input  rx_valid, rx_data,
      output rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err, word_count
   );

   modport slave (
      output rx_valid, rx_data,
      input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err, word_count
   );

endinterface

// File: rtl/imem_loader.sv
// Frame loader: A5, N, 2N data bytes (high first), XOR checksum -> one imem write per word.
// Write issues the cycle after the low byte; rx_ready drops only in that write cycle.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   imem_loader_if.master bus
);

   localparam logic [ADDR_W:0] ONE_WORD   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};

   state_t            state;
   state_t            state_nxt;
   logic              accept;
   logic [ADDR_W-1:0] len_n;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic [ADDR_W:0]   word_count;
   logic [7:0]        csum;
   logic [7:0]        hi;
   logic [7:0]        lo;
   logic              done;
   logic              err;

   assign accept = bus.rx_valid & bus.rx_ready;
   assign len_n  = ADDR_W'(bus.rx_data);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && bus.rx_data == START_BYTE) state_nxt = LEN;
         LEN:     if (accept) state_nxt = HI;
         HI:      if (accept) state_nxt = LO;
         LO:      if (accept) state_nxt = WRITE;
         WRITE:   state_nxt = (remaining == ONE_WORD) ? CSUM : HI;
         CSUM:    if (accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr       <= '0;
         remaining  <= '0;
         word_count <= '0;
         csum       <= '0;
         hi         <= '0;
         lo         <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (accept && bus.rx_data == START_BYTE) err <= 1'b0;
            LEN: if (accept) begin
               // a zero length byte means a full-depth image
               remaining  <= (len_n == '0) ? FULL_DEPTH : {1'b0, len_n};
               addr       <= '0;
               csum       <= '0;
               word_count <= '0;
            end
            HI: if (accept) begin
               hi   <= bus.rx_data;
               csum <= csum ^ bus.rx_data;
            end
            LO: if (accept) begin
               lo   <= bus.rx_data;
               csum <= csum ^ bus.rx_data;
            end
            WRITE: begin
               addr       <= addr + 1'b1;
               word_count <= word_count + 1'b1;
               remaining  <= remaining - 1'b1;
            end
            CSUM: if (accept) begin
               if (bus.rx_data == csum) done <= 1'b1;
               else                     err  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.rx_ready   = (state != WRITE);
   assign bus.imem_we    = (state == WRITE);
   assign bus.imem_addr  = addr;
   assign bus.imem_wdata = {hi, lo};
   assign bus.cpu_hold   = (state != IDLE);
   assign bus.done       = done;
   assign bus.err        = err;
   assign bus.word_count = word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed vector bench for imem_loader: frame table plus full-depth and mid-frame reset sequences.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int ADDR_W = 8;

   typedef struct {
      int                      nbytes;
      logic [0:11][7:0]        bytes;
      int                      sidx;
      int                      nwr;
      logic [0:1][ADDR_W-1:0]  wa;
      logic [0:1][15:0]        wd;
      int                      ndone;
      logic                    err;
      int                      wc;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
   imem_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[5];

   logic [ADDR_W-1:0] wr_addr_q[$];
   logic [15:0]       wr_data_q[$];
   int   done_cnt = 0, done_wide = 0, hold_at_done = 0, stall_cnt = 0, stall_mis = 0;
   logic done_prev = 1'b0;

   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         wr_addr_q.push_back(bus.imem_addr);
         wr_data_q.push_back(bus.imem_wdata);
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         if (done_prev) done_wide++;
         if (bus.cpu_hold !== 1'b0) hold_at_done++;
      end
      done_prev = (bus.done === 1'b1);
      if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b0) stall_cnt++;
      if ((bus.rx_ready === 1'b0) != (bus.imem_we === 1'b1)) stall_mis++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic got;
      got = 1'b0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = (bus.rx_ready === 1'b1);
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL rx_ready_timeout: byte %0h not accepted within 20 cycles", b);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.rx_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input int k, input int nbytes, input logic [0:11][7:0] bytes,
                          input int sidx, input int nwr, input logic [0:1][ADDR_W-1:0] wa,
                          input logic [0:1][15:0] wd, input int ndone, input logic err, input int wc);
      vecs[k].nbytes = nbytes; vecs[k].bytes = bytes; vecs[k].sidx  = sidx;
      vecs[k].nwr    = nwr;    vecs[k].wa    = wa;    vecs[k].wd    = wd;
      vecs[k].ndone  = ndone;  vecs[k].err   = err;   vecs[k].wc    = wc;
   endtask

   task automatic run_vec(input int k);
      vec_t v;
      int   wbase, dbase;
      v     = vecs[k];
      wbase = wr_addr_q.size();
      dbase = done_cnt;
      for (int i = 0; i < v.nbytes; i++) begin
         send_byte(v.bytes[i]);
         if (i == v.sidx) check($sformatf("v%0d_err_clear_on_start", k), bus.err, 0);
      end
      check($sformatf("v%0d_done_next_cycle", k), bus.done, v.ndone);
      check($sformatf("v%0d_err_next_cycle", k), bus.err, v.err);
      check($sformatf("v%0d_hold_released", k), bus.cpu_hold, 0);
      idle(3);
      check($sformatf("v%0d_write_count", k), wr_addr_q.size() - wbase, v.nwr);
      for (int j = 0; j < 2 && j < v.nwr && wbase + j < wr_addr_q.size(); j++) begin
         check($sformatf("v%0d_addr%0d", k, j), wr_addr_q[wbase+j], v.wa[j]);
         check($sformatf("v%0d_data%0d", k, j), wr_data_q[wbase+j], v.wd[j]);
      end
      check($sformatf("v%0d_done_pulses", k), done_cnt - dbase, v.ndone);
      check($sformatf("v%0d_err_sticky", k), bus.err, v.err);
      check($sformatf("v%0d_word_count", k), bus.word_count, v.wc);
   endtask

   initial begin
      logic [7:0] hi, lo, cs;
      int wbase, sbase, mbase, dbase, lat_bad, data_bad;

      set_vec(0, 7, {8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08, 40'h0}, 0, 2,
              {8'h00, 8'h01}, {16'h1234, 16'h5678}, 1, 1'b0, 2);
      set_vec(1, 7, {8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 40'h0}, 0, 2,
              {8'h00, 8'h01}, {16'h1234, 16'h5678}, 0, 1'b1, 2);
      set_vec(2, 8, {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h66, 32'h0}, 3, 1,
              {8'h00, 8'h00}, {16'hABCD, 16'h0000}, 1, 1'b0, 1);
      set_vec(3, 5, {8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h00, 56'h0}, 0, 1,
              {8'h00, 8'h00}, {16'hA5A5, 16'h0000}, 1, 1'b0, 1);
      set_vec(4, 9, {8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 24'h0}, 0, 3,
              {8'h00, 8'h01}, {16'h0102, 16'h0304}, 1, 1'b0, 3);

      rst = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rx_ready", bus.rx_ready, 1);
      check("rst_cpu_hold", bus.cpu_hold, 0);
      check("rst_imem_we", bus.imem_we, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_word_count", bus.word_count, 0);
      check("rst_imem_addr", bus.imem_addr, 0);
      rst = 1'b0;
      idle(2);

      for (int k = 0; k < 5; k++) run_vec(k);

      // Full depth with rx_valid held high: every WRITE must stall the source exactly once.
      wbase = wr_addr_q.size(); sbase = stall_cnt; mbase = stall_mis; dbase = done_cnt;
      lat_bad = 0; data_bad = 0; cs = 8'h00;
      send_byte(8'hA5);
      send_byte(8'h00);
      for (int w = 0; w < 256; w++) begin
         hi = w[7:0];
         lo = ~w[7:0] ^ 8'h3C;
         cs = cs ^ hi ^ lo;
         send_byte(hi);
         send_byte(lo);
         if (bus.imem_we !== 1'b1 || bus.imem_addr !== w[7:0]) lat_bad++;
      end
      send_byte(cs);
      check("full_done_next_cycle", bus.done, 1);
      check("full_addr_wrapped", bus.imem_addr, 0);
      check("full_word_count", bus.word_count, 256);
      check("full_err", bus.err, 0);
      idle(2);
      check("full_write_count", wr_addr_q.size() - wbase, 256);
      for (int j = 0; j < 256 && wbase + j < wr_addr_q.size(); j++) begin
         hi = j[7:0];
         lo = ~j[7:0] ^ 8'h3C;
         if (wr_addr_q[wbase+j] !== j[7:0] || wr_data_q[wbase+j] !== {hi, lo}) data_bad++;
      end
      check("full_write_contents_bad", data_bad, 0);
      check("full_we_after_lo_bad", lat_bad, 0);
      check("full_stall_cycles", stall_cnt - sbase, 256);
      check("full_ready_vs_we_mismatch", stall_mis - mbase, 0);
      check("full_done_pulses", done_cnt - dbase, 1);

      // Reset while the frame sits between the HI and LO bytes.
      wbase = wr_addr_q.size();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h12);
      bus.rx_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_cpu_hold", bus.cpu_hold, 0);
      check("midrst_rx_ready", bus.rx_ready, 1);
      check("midrst_imem_we", bus.imem_we, 0);
      check("midrst_wdata", bus.imem_wdata, 0);
      check("midrst_word_count", bus.word_count, 0);
      rst = 1'b0;
      idle(3);
      check("midrst_no_write", wr_addr_q.size() - wbase, 0);
      run_vec(0);

      check("done_single_cycle_violations", done_wide, 0);
      check("hold_high_with_done", hold_at_done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes 16-bit instruction words into the instruction memory from an 8-bit byte stream. It is the writer side of the instruction-memory interface that the fetch stage reads, and it sits between a byte source (UART receiver or switch/key debug input) and the instruction memory write port. While a frame is loading, it holds the pipeline in reset. It also reports completion, checksum errors and the loaded word count.

## Interface
- ADDR_W, 8, instruction-memory address width; memory depth is 2^ADDR_W words
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  byte available on rx_data
- rx_data  in  8  incoming byte
- rx_ready  out  1  loader can accept a byte; a byte transfers on any cycle with rx_valid & rx_ready
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  16  write data
- cpu_hold  out  1  OR into the pipeline reset; high while a frame is in progress
- done  out  1  one-cycle pulse when a frame ends with a good checksum
- err  out  1  sticky checksum-error flag; cleared when the next start byte is accepted
- word_count  out  ADDR_W+1  number of words written in the current or last frame

## Operation
- Frame format: start byte 0xA5, length byte N, 2·N data bytes, checksum byte.
  - N counts words; N=0 means 2^ADDR_W words (N is truncated to ADDR_W bits when ADDR_W<8).
  - Each word is sent high byte first.
  - The checksum is the XOR of all 2·N data bytes.
- State machine:
  - IDLE: rx_ready=1. Accepted bytes other than 0xA5 are discarded. On 0xA5: clear err, go to LEN.
  - LEN: on accept, load remaining=N (0→2^ADDR_W), clear addr, csum, word_count; go to HI.
  - HI: on accept, hi←byte, csum^=byte; go to LO.
  - LO: on accept, lo←byte, csum^=byte; go to WRITE.
  - WRITE: rx_ready=0, imem_we=1, imem_addr=addr, imem_wdata={hi,lo}. Then addr++ (wraps mod 2^ADDR_W), word_count++, remaining--. Go to CSUM if remaining reaches 0, else to HI.
  - CSUM: on accept, compare the byte with csum. Equal → done pulse; unequal → err=1. Either way go to IDLE.
- cpu_hold=1 in every state except IDLE.
- There is no rollback: words written before a checksum failure remain in memory.
- A value of 0xA5 inside a frame is data and does not restart the frame.
- Reset at any point, including mid-frame:
  - state goes to IDLE.
  - imem_we, cpu_hold, done, err and word_count go to 0.
  - imem_addr and imem_wdata go to 0; rx_ready=1.
  - A WRITE that has not started is not issued.

## Timing
- All outputs are registered or decoded from the registered state; there is no combinational path from rx_* to imem_*.
- imem_we is asserted in the cycle immediately after the cycle in which the LO byte is accepted.
- rx_ready drops in that same WRITE cycle. Bytes presented during WRITE are held by the source and are not lost.
- Maximum throughput is one word per 3 cycles.
- done and err update in the cycle after the checksum byte is accepted. done is exactly one cycle wide.
- cpu_hold deasserts in the same cycle done or err updates. The pipeline restarts fetching at PC 0 one cycle later.
- A frame with N words takes at least 3 + 3·N cycles from the start byte to done.

## Structure
- Shared package imem_loader_pkg holds:
  - the state enum (IDLE, LEN, HI, LO, WRITE, CSUM)
  - START_BYTE = 8'hA5
  - WORD_W = 16
- No sub-module is needed: a single FSM with address, remaining and checksum registers.
- The byte source (UART receiver) is a separate block connected only through rx_valid/rx_ready/rx_data.

## Test plan
- Reset: after rst is held for 2 cycles, rx_ready=1 and cpu_hold, imem_we, done, err and word_count are all 0; the state is IDLE.
- Good frame: send A5 02 12 34 56 78 08. Required: two writes, 0x1234@0 then 0x5678@1, one done pulse, err=0, word_count=2, cpu_hold low after done.
- Bad checksum: send the same frame with checksum FF. Required: both words still written, err=1 and sticky, no done pulse. Sending the next A5 clears err.
- Noise before frame: send 00 FF 5A, then a valid one-word frame A5 01 AB CD 66. Required: the noise bytes are ignored, one write of 0xABCD@0, done pulses.
- Full depth with ADDR_W=8: send length byte 00, 512 data bytes and the correct checksum. Required: 256 writes at addresses 0..255, imem_addr wraps to 0 after the last write, word_count=256. Holding rx_valid high continuously shows rx_ready low exactly in each WRITE cycle.
- Reset mid-frame: assert rst right after the HI byte is accepted. Required: no imem_we, cpu_hold=0, state IDLE. A following good frame loads correctly.
